alu_flag_unit: RTL and testbench

//  Consumer of the alu32 status outputs. Latches V/N/Z into an architectural flag register on ADD/SUB only.

---
 rtl/alu_flag_unit.sv | 150 +++++++++++++++
 tb/tb_alu_flag_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: architectural V/N/Z flag register fed by alu32 on ADD/SUB,
// plus a one-cycle branch-condition evaluator with saturating statistics.
module alu_flag_unit #(
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [3:0]           alu_control_code,
  input  logic                 v_in,
  input  logic                 n_in,
  input  logic                 z_in,
  input  logic                 cond_valid,
  input  logic [3:0]           cond_code,
  output logic                 cond_ready,
  output logic                 result_valid,
  output logic                 taken,
  output logic                 illegal_cond,
  output logic                 v_flag,
  output logic                 n_flag,
  output logic                 z_flag,
  output logic [CNT_WIDTH-1:0] eval_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110
  } alu_op_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000,
    CC_NE = 4'b0001,
    CC_MI = 4'b0010,
    CC_PL = 4'b0011,
    CC_VS = 4'b0100,
    CC_VC = 4'b0101,
    CC_LT = 4'b0110,
    CC_GE = 4'b0111,
    CC_GT = 4'b1000,
    CC_LE = 4'b1001,
    CC_AL = 4'b1110
  } cond_e;

  logic                 r_v, r_n, r_z;
  logic                 r_result_valid;
  logic                 r_taken;
  logic                 r_illegal;
  logic [CNT_WIDTH-1:0] r_eval_cnt;
  logic [CNT_WIDTH-1:0] r_taken_cnt;

  logic w_fw;
  logic w_ready;
  logic w_accept;
  logic w_ev_v, w_ev_n, w_ev_z, w_ev_x;
  logic w_cond_true;
  logic w_cond_illegal;

  // Flag-write detection, request handshake and evaluation-flag selection
  always_comb begin
    w_fw = alu_valid &
           ((alu_control_code == OP_ADD) | (alu_control_code == OP_SUB));
    if (BYPASS != 0) begin
      w_ready = 1'b1;
      // Forward the flags being written this cycle so the request sees them
      w_ev_v  = w_fw ? v_in : r_v;
      w_ev_n  = w_fw ? n_in : r_n;
      w_ev_z  = w_fw ? z_in : r_z;
    end else begin
      // Interlock: a request colliding with a flag write waits one cycle
      w_ready = ~w_fw;
      w_ev_v  = r_v;
      w_ev_n  = r_n;
      w_ev_z  = r_z;
    end
    w_ev_x   = w_ev_n ^ w_ev_v;
    w_accept = cond_valid & w_ready;
  end

  // Condition-code decode against the selected evaluation flags
  always_comb begin
    w_cond_true    = 1'b0;
    w_cond_illegal = 1'b0;
    case (cond_code)
      CC_EQ:   w_cond_true = w_ev_z;
      CC_NE:   w_cond_true = ~w_ev_z;
      CC_MI:   w_cond_true = w_ev_n;
      CC_PL:   w_cond_true = ~w_ev_n;
      CC_VS:   w_cond_true = w_ev_v;
      CC_VC:   w_cond_true = ~w_ev_v;
      CC_LT:   w_cond_true = w_ev_x;
      CC_GE:   w_cond_true = ~w_ev_x;
      CC_GT:   w_cond_true = ~w_ev_z & ~w_ev_x;
      CC_LE:   w_cond_true = w_ev_z | w_ev_x;
      CC_AL:   w_cond_true = 1'b1;
      default: w_cond_illegal = 1'b1;
    endcase
  end

  // Architectural flag register: loads only on ADD/SUB with valid ALU result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= 1'b0;
      r_n <= 1'b0;
      r_z <= 1'b0;
    end else if (w_fw) begin
      r_v <= v_in;
      r_n <= n_in;
      r_z <= z_in;
    end
  end

  // Registered decision: pulse result_valid per accept, hold taken/illegal otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result_valid <= 1'b0;
      r_taken        <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      r_result_valid <= w_accept;
      if (w_accept) begin
        r_taken   <= w_cond_true;
        r_illegal <= w_cond_illegal;
      end
    end
  end

  // Saturating evaluation and taken counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_eval_cnt  <= '0;
      r_taken_cnt <= '0;
    end else if (w_accept) begin
      if (r_eval_cnt != '1) r_eval_cnt <= r_eval_cnt + 1'b1;
      if (w_cond_true && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

  assign cond_ready   = w_ready;
  assign result_valid = r_result_valid;
  assign taken        = r_taken;
  assign illegal_cond = r_illegal;
  assign v_flag       = r_v;
  assign n_flag       = r_n;
  assign z_flag       = r_z;
  assign eval_count   = r_eval_cnt;
  assign taken_count  = r_taken_cnt;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit: a forwarding instance (BYPASS=1, 16-bit
// counters) and an interlocking instance (BYPASS=0, 2-bit counters) share stimulus.
module tb_alu_flag_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid;
  logic [3:0] alu_control_code;
  logic       v_in, n_in, z_in;
  logic       cond_valid;
  logic [3:0] cond_code;

  logic        b_ready, b_rv, b_tk, b_il, b_v, b_n, b_z;
  logic [15:0] b_eval, b_tcnt;
  logic        i_ready, i_rv, i_tk, i_il, i_v, i_n, i_z;
  logic [1:0]  i_eval, i_tcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_flag_unit #(.BYPASS(1), .CNT_WIDTH(16)) u_byp (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_control_code(alu_control_code),
    .v_in(v_in), .n_in(n_in), .z_in(z_in), .cond_valid(cond_valid), .cond_code(cond_code),
    .cond_ready(b_ready), .result_valid(b_rv), .taken(b_tk), .illegal_cond(b_il),
    .v_flag(b_v), .n_flag(b_n), .z_flag(b_z), .eval_count(b_eval), .taken_count(b_tcnt)
  );

  alu_flag_unit #(.BYPASS(0), .CNT_WIDTH(2)) u_ilk (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_control_code(alu_control_code),
    .v_in(v_in), .n_in(n_in), .z_in(z_in), .cond_valid(cond_valid), .cond_code(cond_code),
    .cond_ready(i_ready), .result_valid(i_rv), .taken(i_tk), .illegal_cond(i_il),
    .v_flag(i_v), .n_flag(i_n), .z_flag(i_z), .eval_count(i_eval), .taken_count(i_tcnt)
  );

  typedef struct {
    logic       av;
    logic [3:0] ac;
    logic [2:0] vnz;
    logic       cv;
    logic [3:0] cc;
    logic       rv;
    logic       tk;
    logic       il;
    logic [2:0] fl;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ac, input logic [2:0] vnz,
                       input logic cv, input logic [3:0] cc);
    alu_valid        = av;
    alu_control_code = ac;
    {v_in, n_in, z_in} = vnz;
    cond_valid       = cv;
    cond_code        = cc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 4'b0000);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_b_rv"},    32'(b_rv), 32'd0);
    chk({tag, "_b_tk"},    32'(b_tk), 32'd0);
    chk({tag, "_b_il"},    32'(b_il), 32'd0);
    chk({tag, "_b_flags"}, 32'({b_v, b_n, b_z}), 32'd0);
    chk({tag, "_b_eval"},  32'(b_eval), 32'd0);
    chk({tag, "_b_tcnt"},  32'(b_tcnt), 32'd0);
    chk({tag, "_b_ready"}, 32'(b_ready), 32'd1);
    chk({tag, "_i_rv"},    32'(i_rv), 32'd0);
    chk({tag, "_i_flags"}, 32'({i_v, i_n, i_z}), 32'd0);
    chk({tag, "_i_eval"},  32'(i_eval), 32'd0);
    chk({tag, "_i_ready"}, 32'(i_ready), 32'd1);
  endtask

  initial begin
    // av, alu code, {v,n,z}, cond_valid, cond_code | exp rv, taken, illegal, {v,n,z}
    tbl[0]  = '{1'b1, 4'b0110, 3'b001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b001}; // SUB 10-10
    tbl[1]  = '{1'b0, 4'b0110, 3'b000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 3'b001}; // EQ
    tbl[2]  = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 3'b001}; // NE
    tbl[3]  = '{1'b1, 4'b1100, 3'b010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b001}; // NAND holds
    tbl[4]  = '{1'b1, 4'b0000, 3'b111, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 3'b001}; // AND holds, EQ
    tbl[5]  = '{1'b0, 4'b0110, 3'b110, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b001}; // SUB, invalid
    tbl[6]  = '{1'b1, 4'b0010, 3'b110, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b110}; // ADD 7fff..+7fff..
    tbl[7]  = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 3'b110}; // VS
    tbl[8]  = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 3'b110}; // LT
    tbl[9]  = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, 3'b110}; // GE
    tbl[10] = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 3'b110}; // GT
    tbl[11] = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 3'b110}; // LE
    tbl[12] = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 3'b110}; // MI
    tbl[13] = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 3'b110}; // PL
    tbl[14] = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 3'b110}; // VC
    tbl[15] = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b1, 3'b110}; // illegal 1010
    tbl[16] = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 3'b110}; // AL
    tbl[17] = '{1'b0, 4'b0000, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b110}; // idle holds
    tbl[18] = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 3'b110}; // illegal 1111
    tbl[19] = '{1'b0, 4'b0000, 3'b000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 3'b110}; // EQ, Z=0
    tbl[20] = '{1'b1, 4'b1101, 3'b001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b110}; // XOR holds
    tbl[21] = '{1'b1, 4'b0001, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b110}; // OR holds
    tbl[22] = '{1'b1, 4'b1001, 3'b011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b110}; // NOR holds

    reset = 1'b0;
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 4'b0000);
    #1;
    do_reset();
    chk_cleared("reset");

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].av, tbl[i].ac, tbl[i].vnz, tbl[i].cv, tbl[i].cc);
      step();
      chk($sformatf("row%0d_b_rv", i),    32'(b_rv), 32'(tbl[i].rv));
      chk($sformatf("row%0d_b_tk", i),    32'(b_tk), 32'(tbl[i].tk));
      chk($sformatf("row%0d_b_il", i),    32'(b_il), 32'(tbl[i].il));
      chk($sformatf("row%0d_b_fl", i),    32'({b_v, b_n, b_z}), 32'(tbl[i].fl));
      chk($sformatf("row%0d_i_rv", i),    32'(i_rv), 32'(tbl[i].rv));
      chk($sformatf("row%0d_i_tk", i),    32'(i_tk), 32'(tbl[i].tk));
      chk($sformatf("row%0d_i_il", i),    32'(i_il), 32'(tbl[i].il));
      chk($sformatf("row%0d_i_fl", i),    32'({i_v, i_n, i_z}), 32'(tbl[i].fl));
    end
    // 15 accepts, 7 taken; the 2-bit instance saturates at 3
    chk("tbl_b_eval", 32'(b_eval), 32'd15);
    chk("tbl_b_tcnt", 32'(b_tcnt), 32'd7);
    chk("tbl_i_eval", 32'(i_eval), 32'd3);
    chk("tbl_i_tcnt", 32'(i_tcnt), 32'd3);

    // Flag write and MI request in the same cycle; register starts at 000
    do_reset();
    drive(1'b1, 4'b0110, 3'b010, 1'b1, 4'b0010);
    #1;
    chk("coll_b_ready", 32'(b_ready), 32'd1);
    chk("coll_i_ready", 32'(i_ready), 32'd0);
    step();
    chk("coll_b_rv",    32'(b_rv), 32'd1);
    chk("coll_b_tk",    32'(b_tk), 32'd1);
    chk("coll_b_fl",    32'({b_v, b_n, b_z}), 32'b010);
    chk("coll_i_rv",    32'(i_rv), 32'd0);
    chk("coll_i_fl",    32'({i_v, i_n, i_z}), 32'b010);
    drive(1'b0, 4'b0110, 3'b000, 1'b1, 4'b0010);
    #1;
    chk("retry_i_ready", 32'(i_ready), 32'd1);
    step();
    chk("retry_i_rv",   32'(i_rv), 32'd1);
    chk("retry_i_tk",   32'(i_tk), 32'd1);
    chk("retry_b_rv",   32'(b_rv), 32'd1);
    // Flag write after the decision does not disturb it
    drive(1'b1, 4'b0010, 3'b001, 1'b0, 4'b0000);
    step();
    chk("post_b_rv",    32'(b_rv), 32'd0);
    chk("post_b_tk",    32'(b_tk), 32'd1);
    chk("post_i_tk",    32'(i_tk), 32'd1);
    chk("post_b_fl",    32'({b_v, b_n, b_z}), 32'b001);
    chk("post_b_eval",  32'(b_eval), 32'd2);
    chk("post_i_eval",  32'(i_eval), 32'd1);

    // Accept, then reset the following cycle drops the pending state
    drive(1'b0, 4'b0000, 3'b000, 1'b1, 4'b1110);
    step();
    chk("pre_rst_b_rv", 32'(b_rv), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 4'b0000);
    #1;
    chk_cleared("midrst");

    // Counter saturation: five AL accepts, then an illegal code
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b0000, 3'b000, 1'b1, 4'b1110);
      step();
    end
    chk("sat_b_eval", 32'(b_eval), 32'd5);
    chk("sat_b_tcnt", 32'(b_tcnt), 32'd5);
    chk("sat_i_eval", 32'(i_eval), 32'd3);
    chk("sat_i_tcnt", 32'(i_tcnt), 32'd3);
    drive(1'b0, 4'b0000, 3'b000, 1'b1, 4'b1111);
    step();
    chk("ill_b_eval", 32'(b_eval), 32'd6);
    chk("ill_b_tcnt", 32'(b_tcnt), 32'd5);
    chk("ill_b_il",   32'(b_il), 32'd1);
    chk("ill_b_tk",   32'(b_tk), 32'd0);
    chk("ill_i_eval", 32'(i_eval), 32'd3);
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 4'b0000);
    step();
    chk("idle_b_rv",  32'(b_rv), 32'd0);
    chk("idle_b_il",  32'(b_il), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
